// File: rtl/ps_accumulator.sv
// Partial-sum accumulator: folds K-tile partial sums into a DEPTH-row buffer and
// queues finished rows in a 2-entry FIFO drained over valid/ready.
module ps_accumulator #(
  parameter int unsigned ARRWIDTH  = 8,
  parameter int unsigned WORDWIDTH = 8,
  parameter int unsigned DEPTH     = 16,
  localparam int unsigned ACCW     = 4 * WORDWIDTH,
  localparam int unsigned VW       = ACCW * ARRWIDTH,
  localparam int unsigned RW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic          in_first_i,
  input  logic          in_last_i,
  input  logic [VW-1:0] ps_in_vec_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [VW-1:0] out_vec_o,
  output logic [RW-1:0] out_row_o,
  output logic [15:0]   tiles_done_o
);

  logic [VW-1:0] acc_q [DEPTH];
  logic [RW-1:0] wr_ptr_q;
  logic [1:0]    cnt_q, cnt_d;
  logic          in_ready_q, out_valid_q;
  logic [VW-1:0] head_vec_q, tail_vec_q;
  logic [RW-1:0] head_row_q, tail_row_q;
  logic [15:0]   tiles_q;

  logic          accept, push, pop;
  logic [VW-1:0] sum_vec;

  always_comb begin
    accept  = in_valid_i && in_ready_q;
    push    = accept && in_last_i;
    pop     = out_valid_q && out_ready_i;
    sum_vec = '0;
    for (int l = 0; l < int'(ARRWIDTH); l++) begin
      sum_vec[l*ACCW +: ACCW] = ps_in_vec_i[l*ACCW +: ACCW] +
                                (in_first_i ? '0 : acc_q[wr_ptr_q][l*ACCW +: ACCW]);
    end
  end

  // A push is never presented with cnt_q == 2 since in_ready is low then.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) acc_q[i] <= '0;
    end else if (!clear_i && accept) begin
      acc_q[wr_ptr_q] <= sum_vec;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_vec_q  <= '0;
      head_row_q  <= '0;
      tail_vec_q  <= '0;
      tail_row_q  <= '0;
      tiles_q     <= '0;
    end else if (clear_i) begin
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_vec_q  <= '0;
      head_row_q  <= '0;
      tail_vec_q  <= '0;
      tail_row_q  <= '0;
      tiles_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      in_ready_q  <= (cnt_d < 2'd2);
      out_valid_q <= (cnt_d != 2'd0);
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop && cnt_q == 2'd2) begin
        head_vec_q <= tail_vec_q;
        head_row_q <= tail_row_q;
      end
      if (push) begin
        if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop)) begin
          head_vec_q <= sum_vec;
          head_row_q <= wr_ptr_q;
        end else begin
          tail_vec_q <= sum_vec;
          tail_row_q <= wr_ptr_q;
        end
        if (wr_ptr_q == RW'(DEPTH - 1)) tiles_q <= tiles_q + 16'd1;
      end
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign out_vec_o    = head_vec_q;
  assign out_row_o    = head_row_q;
  assign tiles_done_o = tiles_q;

endmodule

// File: tb/tb_ps_accumulator.sv
// Bench for ps_accumulator: directed scenarios plus random traffic against a
// queue-based reference model of the row accumulator.
module tb_ps_accumulator;
  localparam int unsigned AW = 2;
  localparam int unsigned WW = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned VW = 4 * WW * AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0, in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic          out_ready = 1'b1;
  logic [VW-1:0] ps_in = '0;
  logic          in_ready, out_valid;
  logic [VW-1:0] out_vec;
  logic [1:0]    out_row;
  logic [15:0]   tiles_done;

  ps_accumulator #(.ARRWIDTH(AW), .WORDWIDTH(WW), .DEPTH(D)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear_i      (clear),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_first_i   (in_first),
    .in_last_i    (in_last),
    .ps_in_vec_i  (ps_in),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_vec_o    (out_vec),
    .out_row_o    (out_row),
    .tiles_done_o (tiles_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lane [AW];
    int          row;
  } row_t;

  logic [31:0] m_acc [D][AW];
  int          m_ptr;
  int          m_tiles;
  row_t        m_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input bit keep_acc);
    m_ptr   = 0;
    m_tiles = 0;
    m_q.delete();
    if (!keep_acc)
      for (int r = 0; r < int'(D); r++)
        for (int l = 0; l < int'(AW); l++) m_acc[r][l] = '0;
  endtask

  task automatic compare_outputs();
    check_eq("in_ready", 64'(in_ready), 64'(m_q.size() < 2));
    check_eq("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
    check_eq("tiles_done", 64'(tiles_done), 64'(m_tiles % 65536));
    if (m_q.size() != 0) begin
      check_eq("out_vec", 64'(out_vec), {m_q[0].lane[1], m_q[0].lane[0]});
      check_eq("out_row", 64'(out_row), 64'(m_q[0].row));
    end
  endtask

  // Applies the inputs seen at the last rising edge to the reference model.
  task automatic model_step();
    bit   acc_ok;
    row_t r;
    if (clear) begin
      model_reset(1'b1);
      return;
    end
    acc_ok = in_valid && (m_q.size() < 2);
    if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
    if (acc_ok) begin
      for (int l = 0; l < int'(AW); l++) begin
        r.lane[l] = ps_in[l*32 +: 32] + (in_first ? 32'd0 : m_acc[m_ptr][l]);
        m_acc[m_ptr][l] = r.lane[l];
      end
      r.row = m_ptr;
      if (in_last) begin
        m_q.push_back(r);
        if (m_ptr == int'(D) - 1) m_tiles++;
      end
      m_ptr = (m_ptr + 1) % int'(D);
    end
  endtask

  task automatic cyc(input bit v, input bit f, input bit l, input logic [31:0] a,
                     input logic [31:0] b, input bit ordy, input bit clr);
    @(negedge clk);
    compare_outputs();
    in_valid  = v;
    in_first  = f;
    in_last   = l;
    ps_in     = {b, a};
    out_ready = ordy;
    clear     = clr;
    @(posedge clk);
    model_step();
  endtask

  initial begin
    model_reset(1'b0);
    repeat (2) @(negedge clk);
    #1 check_eq("reset_out_vec", 64'(out_vec), 64'd0);
    reset_n = 1'b1;

    // Three K-tiles across all four rows.
    for (int t = 0; t < 3; t++)
      for (int r = 0; r < int'(D); r++)
        cyc(1'b1, t == 0, t == 2, (t == 0) ? 1 : (t == 1) ? 10 : 100,
            (t == 0) ? 2 : (t == 1) ? 20 : 200, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);

    // Single-tile row, then a wrapping first/last pair.
    cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 32'd2, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);

    // Backpressure: queue fills to two, then drains in order.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b1, 32'(i + 40), 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);

    // Steady push+pop with one row in flight.
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 1'b1, 32'(i * 3), 32'(i), 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);

    // clear with a beat present after two accepted beats.
    cyc(1'b1, 1'b1, 1'b0, 7, 7, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 8, 8, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 9, 9, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 11, 12, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);

    // Asynchronous reset with one row queued.
    cyc(1'b1, 1'b1, 1'b1, 5, 6, 1'b0, 1'b0);
    @(negedge clk);
    compare_outputs();
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check_eq("async_rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("async_rst_tiles", 64'(tiles_done), 64'd0);
    model_reset(1'b0);
    #2 reset_n = 1'b1;
    @(posedge clk);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 3) == 0, $urandom, $urandom,
          ($urandom % 4) != 0, ($urandom % 60) == 0);
    @(negedge clk);
    compare_outputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
